// File: rtl/alu_pkg.sv
// Shared constants and the decoded-beat type for the ALU issue slot.
// The optional skid entry in alu_issue is enabled by defining ALU_ISSUE_SKID_EN.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       aluc;
        logic [4:0]       wreg;
        logic             we;
        logic             illegal;
    } alu_issue_t;

    function automatic logic [ALU_W-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [ALU_W-1:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode of instr/rs/rt into ALU operands and writeback control.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]      instr,
    input  logic [ALU_W-1:0] rs_val,
    input  logic [ALU_W-1:0] rt_val,
    output alu_issue_t       dec
);

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;

    assign opcode_s = instr[31:26];
    assign rt_s     = instr[20:16];
    assign rd_s     = instr[15:11];
    assign shamt_s  = instr[10:6];
    assign funct_s  = instr[5:0];
    assign imm_s    = instr[15:0];

    alu_issue_t raw_s;
    logic       legal_s;
    logic       writes_s;

    // Field selection per instruction class; illegal encodings collapse to an all-zero beat.
    always_comb begin
        raw_s      = '0;
        legal_s    = 1'b1;
        writes_s   = 1'b1;
        raw_s.a    = rs_val;
        raw_s.b    = rt_val;
        raw_s.wreg = rt_s;
        case (opcode_s)
            OP_RTYPE: begin
                raw_s.wreg = rd_s;
                case (funct_s)
                    FN_ADD:  raw_s.aluc = ALUC_ADD;
                    FN_ADDU: raw_s.aluc = ALUC_ADDU;
                    FN_SUB:  raw_s.aluc = ALUC_SUB;
                    FN_SUBU: raw_s.aluc = ALUC_SUBU;
                    FN_AND:  raw_s.aluc = ALUC_AND;
                    FN_OR:   raw_s.aluc = ALUC_OR;
                    FN_XOR:  raw_s.aluc = ALUC_XOR;
                    FN_NOR:  raw_s.aluc = ALUC_NOR;
                    FN_SLT:  raw_s.aluc = ALUC_SLT;
                    FN_SLTU: raw_s.aluc = ALUC_SLTU;
                    FN_SLL:  begin raw_s.aluc = ALUC_SLL; raw_s.a = {27'd0, shamt_s};     end
                    FN_SRL:  begin raw_s.aluc = ALUC_SRL; raw_s.a = {27'd0, shamt_s};     end
                    FN_SRA:  begin raw_s.aluc = ALUC_SRA; raw_s.a = {27'd0, shamt_s};     end
                    FN_SLLV: begin raw_s.aluc = ALUC_SLL; raw_s.a = {27'd0, rs_val[4:0]}; end
                    FN_SRLV: begin raw_s.aluc = ALUC_SRL; raw_s.a = {27'd0, rs_val[4:0]}; end
                    FN_SRAV: begin raw_s.aluc = ALUC_SRA; raw_s.a = {27'd0, rs_val[4:0]}; end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDI:  begin raw_s.aluc = ALUC_ADD;  raw_s.b = sext16(imm_s); end
            OP_ADDIU: begin raw_s.aluc = ALUC_ADDU; raw_s.b = sext16(imm_s); end
            OP_SLTI:  begin raw_s.aluc = ALUC_SLT;  raw_s.b = sext16(imm_s); end
            OP_SLTIU: begin raw_s.aluc = ALUC_SLTU; raw_s.b = sext16(imm_s); end
            OP_ANDI:  begin raw_s.aluc = ALUC_AND;  raw_s.b = zext16(imm_s); end
            OP_ORI:   begin raw_s.aluc = ALUC_OR;   raw_s.b = zext16(imm_s); end
            OP_XORI:  begin raw_s.aluc = ALUC_XOR;  raw_s.b = zext16(imm_s); end
            OP_LUI:   begin raw_s.aluc = ALUC_LUI;  raw_s.b = zext16(imm_s); raw_s.a = 32'd0; end
            OP_LW:    begin raw_s.aluc = ALUC_ADDU; raw_s.b = sext16(imm_s); end
            OP_SW:    begin raw_s.aluc = ALUC_ADDU; raw_s.b = sext16(imm_s); writes_s = 1'b0; end
            OP_BEQ, OP_BNE: begin
                raw_s.aluc = ALUC_SUBU;
                raw_s.wreg = 5'd0;
                writes_s   = 1'b0;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Final beat: $0 never gets written.
    always_comb begin
        dec = '0;
        if (legal_s) begin
            dec         = raw_s;
            dec.we      = writes_s && (raw_s.wreg != 5'd0);
            dec.illegal = 1'b0;
        end else begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Registered valid/ready issue slot feeding the ALU; decode happens in alu_decode.
// Define ALU_ISSUE_SKID_EN to add a skid entry that registers in_ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_aluc,
    output logic [4:0]        out_wreg,
    output logic              out_we,
    output logic              out_illegal
);

    alu_issue_t dec_s;
    alu_issue_t out_q;
    alu_issue_t out_d;
    logic       out_valid_q;
    logic       out_valid_d;
    logic       take_s;
    logic       drain_s;

    alu_decode u_decode (
        .instr  (instr),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .dec    (dec_s)
    );

    assign take_s  = in_valid && in_ready;
    assign drain_s = out_valid_q && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    alu_issue_t skid_q;
    alu_issue_t skid_d;
    logic       skid_valid_q;
    logic       skid_valid_d;
    logic       in_ready_q;
    logic       in_ready_d;

    // in_ready_q mirrors "skid empty"; reset and flush only gate it, out_ready never reaches it.
    assign in_ready = rst_n && !flush && in_ready_q;

    // Slot/skid next state: skid refills the slot on drain, stalled accepts park in the skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain_s) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (take_s) begin
                out_d       = dec_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (take_s) begin
            if (out_valid_q) begin
                skid_d       = dec_s;
                skid_valid_d = 1'b1;
            end else begin
                out_d       = dec_s;
                out_valid_d = 1'b1;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);

    // Single slot: reload on accept (covers drain+accept with no bubble), empty on drain.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (take_s) begin
            out_d       = dec_s;
            out_valid_d = 1'b1;
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign out_valid   = out_valid_q;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_aluc    = out_q.aluc;
    assign out_wreg    = out_q.wreg;
    assign out_we      = out_q.we;
    assign out_illegal = out_q.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage entry block that sits directly upstream of the 4-bit-`aluc` ALU. It decodes a MIPS instruction word together with its register operands into the ALU's `a`, `b` and `aluc` inputs plus writeback control. The result is held in a registered valid/ready pipeline slot, so the ALU and downstream logic see stable, registered operands. An optional skid entry decouples `in_ready` from `out_ready`.

## Interface
- `DATA_W`, 32: operand width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `flush`  in  1  synchronous squash of all held beats.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept this cycle.
- `instr`  in  32  instruction word.
- `rs_val`  in  DATA_W  register value of the rs field.
- `rt_val`  in  DATA_W  register value of the rt field.
- `out_valid`  out  1  registered beat valid.
- `out_ready`  in  1  downstream (ALU/EX register) accepts.
- `out_a`  out  DATA_W  ALU operand a.
- `out_b`  out  DATA_W  ALU operand b.
- `out_aluc`  out  4  ALU opcode.
- `out_wreg`  out  5  destination register.
- `out_we`  out  1  register write enable.
- `out_illegal`  out  1  unrecognised instruction.

## Operation
- A beat transfers on `in_valid && in_ready`; an output transfers on `out_valid && out_ready`.
- aluc codes:
  - ADDU=0000, ADD=0010, SUBU=0001, SUB=0011
  - AND=0100, OR=0101, XOR=0110, NOR=0111
  - LUI=1000, SLTU=1010, SLT=1011
  - SRA=1100, SRL=1101, SLL=1110
- R-type (opcode 0x00), funct to aluc:
  - add 0x20 / addu 0x21 / sub 0x22 / subu 0x23
  - and 0x24 / or 0x25 / xor 0x26 / nor 0x27
  - slt 0x2A / sltu 0x2B
  - For these: a=rs_val, b=rt_val.
- Shifts:
  - sll 0x00 / srl 0x02 / sra 0x03: a={27'b0,shamt}, b=rt_val.
  - sllv 0x04 / srlv 0x06 / srav 0x07: a={27'b0,rs_val[4:0]}, b=rt_val.
  - Destination = rd.
- I-type (a=rs_val, b=imm16 extended, destination = rt):
  - addi 0x08 ADD, sign-extended
  - addiu 0x09 ADDU, sign-extended
  - slti 0x0A SLT, sign-extended
  - sltiu 0x0B SLTU, sign-extended
  - andi 0x0C / ori 0x0D / xori 0x0E, zero-extended
  - lui 0x0F LUI, b={16'b0,imm16}, a=0
  - lw 0x23: ADDU, sign-extended, we=1
  - sw 0x2B: ADDU, sign-extended, we=0
- beq 0x04 / bne 0x05: SUBU, a=rs_val, b=rt_val, we=0.
- `out_we` is forced to 0 when `out_wreg`==0.
- Any other opcode/funct: out_illegal=1, aluc=0000, a=b=0, we=0, wreg=0.

## Timing
- Latency: a beat accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset (rst_n=0 at an edge):
  - out_valid=0, all data outputs 0, skid empty.
  - in_ready=0 while rst_n=0; 1 from the first cycle after release.
- Flush:
  - out_valid and the skid are cleared at the edge.
  - in_ready=0 during the flush cycle, so no beat is accepted.
  - Flush wins over a simultaneous accept or drain.
- Without skid: in_ready = !out_valid || out_ready (combinational path).
- Simultaneous drain and accept: the slot reloads the new beat in the same edge, with no bubble.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Adds one skid entry; in_ready is a register equal to "skid empty".
  - A beat accepted while the output is stalled goes to the skid.
  - When the output drains, the skid moves to the output at the next edge, with in_ready=1 again the cycle after.
  - There is no combinational path from out_ready to in_ready.
  - Full = output and skid both valid.
- Undefined: single slot only, with in_ready as in Timing.

## Structure
- Package `alu_pkg`:
  - aluc localparams (ALUC_ADD etc.)
  - opcode/funct constants
  - packed struct `alu_issue_t` {a, b, aluc, wreg, we, illegal}
- Sub-module `alu_decode`: purely combinational instr/rs/rt to `alu_issue_t`. The parent holds the slot, the skid and the handshake.

## Test plan
- addi: instr=0x2008FFFF, rs_val=5 -> next cycle out_a=5, out_b=0xFFFFFFFF, aluc=0010, wreg=8, we=1.
- sra: instr=0x00084083 (sra $8,$8,2), rt_val=0x80000000 -> out_a=2, out_b=0x80000000, aluc=1100, wreg=8.
- ori to $0: instr=0x3400ABCD -> out_b=0x0000ABCD, aluc=0101, we=0. Opcode 0x3F -> out_illegal=1, we=0.
- Back-pressure: hold out_ready=0 for 3 cycles with a continuous in_valid stream.
  - Without skid: exactly 1 beat accepted.
  - With skid: 2 beats accepted.
  - On release, beats emerge in order with no duplication or loss.
- Flush with a full skid and in_valid=1 -> next cycle out_valid=0, nothing accepted in the flush cycle.
- Reset mid-stall: rst_n=0 for 1 cycle with out_valid=1 -> out_valid=0 and outputs 0. in_ready=1 the cycle after rst_n returns high.
